// File: rtl/approx_mult_pkg.sv
// Shared definitions for the approximate-multiplier controller: state encoding
// and datapath sizing constants.
package approx_mult_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    INIT  = 4'd1,
    LOAD1 = 4'd2,
    LOAD2 = 4'd3,
    NORM  = 4'd4,
    LDRES = 4'd5,
    SHRES = 4'd6,
    WRITE = 4'd7,
    DONE  = 4'd8
  } state_t;

  localparam int unsigned RES_SHIFT_BASE = 16;
  localparam int unsigned NUM_WORDS      = 16;
  localparam int unsigned MAX_NORM       = 7;

endpackage

// File: rtl/approx_mult_ctrl_chk.sv
// Protocol checker for approx_mult_ctrl: the load counter parity must match
// the operand being loaded (even word -> operand 1, odd word -> operand 2).
module approx_mult_ctrl_chk (
  input logic clk,
  input logic rst,
  input logic load_shift1,
  input logic load_shift2,
  input logic lsb_cnt
);

  a_lsb_load1 : assert property (@(posedge clk) disable iff (!rst) load_shift1 |-> !lsb_cnt);
  a_lsb_load2 : assert property (@(posedge clk) disable iff (!rst) load_shift2 |-> lsb_cnt);
  a_one_load  : assert property (@(posedge clk) disable iff (!rst) !(load_shift1 && load_shift2));

endmodule

// File: rtl/approx_mult_ctrl.sv
// Sequencing FSM for the approximate-multiplier datapath: 8 operand pairs per run.
// Optional cycle counter enabled by defining APPROX_MULT_PERF_EN.
module approx_mult_ctrl
  import approx_mult_pkg::*;
#(
  parameter int PERF_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic lsb_cnt,
  input  logic co_cntr_ld,
  input  logic end_shift1,
  input  logic end_shift2,
  input  logic co_cnt_sh,
  output logic cntr_ld_init,
  output logic cntr_ld_en,
  output logic cntr_sh1_init,
  output logic cntr_sh2_init,
  output logic cntr_sh1_en,
  output logic cntr_sh2_en,
  output logic cntr_sh_ld,
  output logic cntr_sh_en,
  output logic load_shift1,
  output logic load_shift2,
  output logic en_shift1,
  output logic en_shift2,
  output logic sh_result_ld,
  output logic sh_result_shift,
  output logic wr_out_ram,
  output logic busy,
  output logic done
`ifdef APPROX_MULT_PERF_EN
  ,
  output logic [PERF_W-1:0] cycle_count
`endif
);

  state_t state_r;
  state_t state_s;
  logic   last_pair_r;

  // state register; async reset aborts any run in progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // last-pair flag; a counter at 15 is always odd, so lsb_cnt guards a corrupt count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_pair_r <= 1'b0;
    end else if (state_r == LOAD2) begin
      last_pair_r <= co_cntr_ld & lsb_cnt;
    end
  end

  // next-state and control decode
  always_comb begin
    state_s         = state_r;
    cntr_ld_init    = 1'b0;
    cntr_ld_en      = 1'b0;
    cntr_sh1_init   = 1'b0;
    cntr_sh2_init   = 1'b0;
    cntr_sh1_en     = 1'b0;
    cntr_sh2_en     = 1'b0;
    cntr_sh_ld      = 1'b0;
    cntr_sh_en      = 1'b0;
    load_shift1     = 1'b0;
    load_shift2     = 1'b0;
    en_shift1       = 1'b0;
    en_shift2       = 1'b0;
    sh_result_ld    = 1'b0;
    sh_result_shift = 1'b0;
    wr_out_ram      = 1'b0;
    done            = 1'b0;
    busy            = (state_r != IDLE);
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = INIT;
        end else begin
          state_s = IDLE;
        end
      end
      INIT: begin
        cntr_ld_init  = 1'b1;
        cntr_sh1_init = 1'b1;
        cntr_sh2_init = 1'b1;
        state_s       = LOAD1;
      end
      LOAD1: begin
        load_shift1 = 1'b1;
        cntr_ld_en  = 1'b1;
        state_s     = LOAD2;
      end
      LOAD2: begin
        load_shift2 = 1'b1;
        cntr_ld_en  = 1'b1;
        state_s     = NORM;
      end
      NORM: begin
        // both operands normalise independently; leave once neither wants a shift
        en_shift1   = end_shift1;
        cntr_sh1_en = end_shift1;
        en_shift2   = end_shift2;
        cntr_sh2_en = end_shift2;
        if (!end_shift1 && !end_shift2) begin
          state_s = LDRES;
        end else begin
          state_s = NORM;
        end
      end
      LDRES: begin
        sh_result_ld = 1'b1;
        cntr_sh_ld   = 1'b1;
        state_s      = SHRES;
      end
      SHRES: begin
        sh_result_shift = 1'b1;
        cntr_sh_en      = 1'b1;
        if (co_cnt_sh) begin
          state_s = WRITE;
        end else begin
          state_s = SHRES;
        end
      end
      WRITE: begin
        wr_out_ram = 1'b1;
        if (last_pair_r) begin
          state_s = DONE;
        end else begin
          cntr_sh1_init = 1'b1;
          cntr_sh2_init = 1'b1;
          state_s       = LOAD1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

`ifdef APPROX_MULT_PERF_EN
  logic [PERF_W-1:0] cycle_count_r;

  // run-length counter; INIT restarts it and counts itself as the first busy cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_count_r <= {PERF_W{1'b0}};
    end else if (state_r == INIT) begin
      cycle_count_r <= {{(PERF_W-1){1'b0}}, 1'b1};
    end else if (busy && (cycle_count_r != {PERF_W{1'b1}})) begin
      cycle_count_r <= cycle_count_r + {{(PERF_W-1){1'b0}}, 1'b1};
    end
  end

  assign cycle_count = cycle_count_r;
`endif

endmodule

// File: tb/tb_approx_mult_ctrl.sv
// Bench for approx_mult_ctrl: behavioural datapath around the controller,
// expected writes queued at stimulus time and checked by an independent monitor.
module tb_approx_mult_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic lsb_cnt, co_cntr_ld, end_shift1, end_shift2, co_cnt_sh;
  logic cntr_ld_init, cntr_ld_en, cntr_sh1_init, cntr_sh2_init;
  logic cntr_sh1_en, cntr_sh2_en, cntr_sh_ld, cntr_sh_en;
  logic load_shift1, load_shift2, en_shift1, en_shift2;
  logic sh_result_ld, sh_result_shift, wr_out_ram, busy, done;
`ifdef APPROX_MULT_PERF_EN
  logic [15:0] cycle_count;
`endif

  always #5 clk = ~clk;

  approx_mult_ctrl #(.PERF_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .lsb_cnt(lsb_cnt), .co_cntr_ld(co_cntr_ld),
    .end_shift1(end_shift1), .end_shift2(end_shift2), .co_cnt_sh(co_cnt_sh),
    .cntr_ld_init(cntr_ld_init), .cntr_ld_en(cntr_ld_en),
    .cntr_sh1_init(cntr_sh1_init), .cntr_sh2_init(cntr_sh2_init),
    .cntr_sh1_en(cntr_sh1_en), .cntr_sh2_en(cntr_sh2_en),
    .cntr_sh_ld(cntr_sh_ld), .cntr_sh_en(cntr_sh_en),
    .load_shift1(load_shift1), .load_shift2(load_shift2),
    .en_shift1(en_shift1), .en_shift2(en_shift2),
    .sh_result_ld(sh_result_ld), .sh_result_shift(sh_result_shift),
    .wr_out_ram(wr_out_ram), .busy(busy), .done(done)
`ifdef APPROX_MULT_PERF_EN
    , .cycle_count(cycle_count)
`endif
  );

  approx_mult_ctrl_chk u_chk (
    .clk(clk), .rst(rst), .load_shift1(load_shift1),
    .load_shift2(load_shift2), .lsb_cnt(lsb_cnt)
  );

  logic [16:0] outs;
  assign outs = {cntr_ld_init, cntr_ld_en, cntr_sh1_init, cntr_sh2_init, cntr_sh1_en,
                 cntr_sh2_en, cntr_sh_ld, cntr_sh_en, load_shift1, load_shift2, en_shift1,
                 en_shift2, sh_result_ld, sh_result_shift, wr_out_ram, busy, done};

  // behavioural datapath
  logic [15:0] ram [16];
  logic [15:0] op1, op2;
  logic [2:0]  c1, c2;
  logic [3:0]  ld_cnt, sh_cnt;
  logic [31:0] res;

  assign lsb_cnt    = ld_cnt[0];
  assign co_cntr_ld = (ld_cnt == 4'd15);
  assign end_shift1 = !op1[15] && (c1 != 3'd7);
  assign end_shift2 = !op2[15] && (c2 != 3'd7);
  assign co_cnt_sh  = (sh_cnt == 4'd15);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      op1 <= 16'd0; op2 <= 16'd0; c1 <= 3'd0; c2 <= 3'd0;
      ld_cnt <= 4'd0; sh_cnt <= 4'd0; res <= 32'd0;
    end else begin
      if (cntr_ld_init) ld_cnt <= 4'd0;
      else if (cntr_ld_en) ld_cnt <= ld_cnt + 4'd1;
      if (cntr_sh1_init) c1 <= 3'd0;
      else if (cntr_sh1_en) c1 <= c1 + 3'd1;
      if (cntr_sh2_init) c2 <= 3'd0;
      else if (cntr_sh2_en) c2 <= c2 + 3'd1;
      if (load_shift1) op1 <= ram[ld_cnt];
      else if (en_shift1) op1 <= {op1[14:0], 1'b0};
      if (load_shift2) op2 <= ram[ld_cnt];
      else if (en_shift2) op2 <= {op2[14:0], 1'b0};
      if (sh_result_ld) res <= 32'(op1[15:8]) * 32'(op2[15:8]);
      else if (sh_result_shift) res <= {res[30:0], 1'b0};
      if (cntr_sh_ld) sh_cnt <= {1'b0, c1} + {1'b0, c2};
      else if (cntr_sh_en) sh_cnt <= sh_cnt + 4'd1;
    end
  end

  typedef struct {
    logic [31:0] data;
    int          norm;
    int          shres;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int init_cnt = 0, done_cnt = 0, wr_cnt = 0, ldres_cnt = 0;
  int norm_cnt = 0, shres_cnt = 0;
  bit in_norm  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input int nrm, input int shr);
    exp_t e;
    e.data = d; e.norm = nrm; e.shres = shr;
    exp_q.push_back(e);
  endtask

  task automatic push_std(input int n);
    for (int i = 0; i < n; i++) push_exp(32'h4000_0000, 1, 16);
  endtask

  task automatic load_image_a();
    for (int i = 0; i < 16; i++) ram[i] = 16'h8000;
  endtask

  // image B pairs and hand-computed results
  task automatic load_image_b();
    ram[0] = 16'h0001; ram[1] = 16'hFFFF;
    ram[2] = 16'h0100; ram[3] = 16'h0100;
    ram[4] = 16'h1234; ram[5] = 16'h0F0F;
    ram[6] = 16'h4000; ram[7] = 16'h00C0;
    ram[8] = 16'h0000; ram[9] = 16'hC000;
    for (int i = 10; i < 16; i++) ram[i] = 16'h8000;
  endtask

  task automatic push_b();
    push_exp(32'h0000_0000, 8, 9);
    push_exp(32'h0001_0000, 8, 2);
    push_exp(32'h010F_E000, 5, 9);
    push_exp(32'h0030_0000, 8, 8);
    push_exp(32'h0000_0000, 8, 9);
    push_std(3);
  endtask

  // monitor: measures per-pair timing and checks every write against the queue
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        in_norm = 1'b0; norm_cnt = 0; shres_cnt = 0;
      end else begin
        if (cntr_ld_init) init_cnt++;
        if (done) done_cnt++;
        if (sh_result_ld) ldres_cnt++;
        if (load_shift2) begin
          in_norm = 1'b1; norm_cnt = 0;
        end else if (sh_result_ld) begin
          in_norm = 1'b0;
        end else if (in_norm) begin
          norm_cnt++;
        end
        if (sh_result_shift) shres_cnt++;
        if (wr_out_ram) begin
          check("write_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wr_data", res, e.data);
            check("norm_cycles", 32'(norm_cnt), 32'(e.norm));
            check("shres_cycles", 32'(shres_cnt), 32'(e.shres));
          end
          shres_cnt = 0;
          wr_cnt++;
        end
      end
    end
  end

  task automatic wait_done(input int budget);
    bit got = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(got), 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, w0, i0, l0;
    bit seen;
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 16; i++) ram[i] = 16'h0000;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", 32'(outs), 32'd0);
    rst = 1'b1;
    @(negedge clk); #1;
    check("idle_outputs", 32'(outs), 32'd0);

    // run A: all words 8000
    load_image_a(); push_std(8);
    d0 = done_cnt; w0 = wr_cnt;
    pulse_start();
    check("init_after_start", 32'(cntr_ld_init), 32'd1);
    wait_done(1000);
    @(negedge clk); #1;
    check("done_single_cycle", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    check("done_count_a", 32'(done_cnt - d0), 32'd1);
    check("writes_a", 32'(wr_cnt - w0), 32'd8);
    check("queue_empty_a", 32'(exp_q.size()), 32'd0);
`ifdef APPROX_MULT_PERF_EN
    check("cycle_count_a", 32'(cycle_count), 32'd170);
    repeat (5) @(negedge clk);
    #1;
    check("cycle_count_hold", 32'(cycle_count), 32'd170);
`endif

    // run B: edge-case operands, start pulsed in NORM, then held through DONE
    load_image_b(); push_b(); push_b();
    i0 = init_cnt; d0 = done_cnt; w0 = wr_cnt;
    pulse_start();
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (load_shift2) begin
        seen = 1'b1;
        break;
      end
    end
    check("reach_load2", 32'(seen), 32'd1);
    @(negedge clk);
    pulse_start();
    seen = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk); #1;
      if (wr_cnt - w0 >= 4) begin
        seen = 1'b1;
        break;
      end
    end
    check("reach_write4", 32'(seen), 32'd1);
    start = 1'b1;
    wait_done(1000);
    #1;
    check("midrun_start_ignored", 32'(init_cnt - i0), 32'd1);
    @(negedge clk); #1;
    check("idle_gap", 32'(busy), 32'd0);
    check("idle_gap_no_init", 32'(cntr_ld_init), 32'd0);
    @(negedge clk); #1;
    check("init_2_after_done", 32'(cntr_ld_init), 32'd1);
    check("init_count_b", 32'(init_cnt - i0), 32'd2);
    start = 1'b0;
    wait_done(1000);
    @(negedge clk); #1;
    check("writes_b", 32'(wr_cnt - w0), 32'd16);
    check("done_count_b", 32'(done_cnt - d0), 32'd2);
    check("queue_empty_b", 32'(exp_q.size()), 32'd0);

    // run C: reset during SHRES of the third pair
    load_image_a(); push_std(2);
    l0 = ldres_cnt;
    pulse_start();
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (ldres_cnt - l0 == 3) begin
        seen = 1'b1;
        break;
      end
    end
    check("reach_ldres3", 32'(seen), 32'd1);
    @(negedge clk);
    check("in_shres", 32'(sh_result_shift), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("abort_outputs", 32'(outs), 32'd0);
    check("queue_empty_c", 32'(exp_q.size()), 32'd0);
    w0 = wr_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    check("no_write_after_reset", 32'(wr_cnt - w0), 32'd0);
    check("idle_after_reset", 32'(busy), 32'd0);
    push_std(8);
    w0 = wr_cnt;
    pulse_start();
    wait_done(1000);
    @(negedge clk); #1;
    check("writes_c", 32'(wr_cnt - w0), 32'd8);
    check("queue_empty_final", 32'(exp_q.size()), 32'd0);
`ifdef APPROX_MULT_PERF_EN
    check("cycle_count_c", 32'(cycle_count), 32'd170);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
